rv32m_mul_sequencer: RTL
========================

# rv32m_mul_sequencer

Iterative RV32M multiply unit for the out-of-order core's multiply functional unit. It accepts one MUL/MULH/MULHSU/MULHU operation and splits the 32x32 product into sixteen 8x8 sub-products. Each sub-product is computed by an internal `dadda_multiplier8` instance. The block accumulates the sub-products into a 64-bit sum, applies sign fix-up and returns the selected 32-bit half with the instruction's tag. It sits between reservation-station issue and the CDB/ROB writeback arbiter.

## Interface
- `TAG_WIDTH`, default 5: width of the destination tag carried with the operation.
- `clk`  in  1: clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `move_flush`  in  1: synchronous pipeline flush. Same effect as `rst`; it is also wired to the `dadda_multiplier8` instance.
- `start`  in  1: operation request. Accepted only in IDLE.
- `mulop`  in  2: operation select. 00=MUL, 01=MULH, 10=MULHSU, 11=MULHU (funct3[1:0] order).
- `a`  in  32: rs1 operand. Sampled only on the accept cycle.
- `b`  in  32: rs2 operand. Sampled only on the accept cycle.
- `tag_in`  in  TAG_WIDTH: destination tag. Sampled on accept.
- `busy`  out  1: state != IDLE.
- `done`  out  1: one-cycle pulse; `result` and `tag_out` are valid on this cycle.
- `result`  out  32: registered result. Holds its value until the next completion.
- `tag_out`  out  TAG_WIDTH: registered tag of the completed operation.

## Operation
- FSM states: IDLE, LOAD, CSTART, CWAIT, FIXUP, DONE.
- IDLE:
  - With `start`=1, capture `mulop`, `a`, `b` and `tag_in`, then go to LOAD.
  - With `start`=0, stay in IDLE.
- `start` in any other state is ignored and has no side effects.
- Signedness:
  - a_signed = (mulop==01 or 10).
  - b_signed = (mulop==01).
  - MUL is treated as unsigned; its low word is identical either way.
- LOAD:
  - Register the magnitudes |a| and |b|. An operand is negated (two's complement) only when its signed flag is set and bit31 is 1.
  - 0x80000000 has magnitude 0x80000000, which fits in an unsigned 32-bit value.
  - Register neg = (a_signed&a[31]) ^ (b_signed&b[31]).
  - Clear the 64-bit accumulator and the 4-bit chunk counter k.
  - Go to CSTART.
- Chunk selection, held constant from CSTART through the end of CWAIT:
  - ai = k[3:2], bi = k[1:0].
  - Sub-multiplier input a = |a| byte ai; sub-multiplier input b = |b| byte bi.
- CSTART:
  - Drive sub-multiplier `start`=1 for exactly this cycle.
  - Go to CWAIT.
- CWAIT:
  - Sub-multiplier `start`=0.
  - When the sub-multiplier's `done`=1, update acc += zero-extended 16-bit p << 8*(ai+bi). The sum is 64 bits wide with no overflow.
  - On the same edge, if k==15 go to FIXUP; otherwise increment k and go to CSTART.
  - Because sub-multiplier `start`=0 when its `done` is seen, the sub-multiplier returns to its idle stage on that same edge.
- FIXUP:
  - If neg, acc = -acc (64-bit two's complement).
  - Go to DONE.
- DONE:
  - `result` = acc[31:0] for MUL, otherwise acc[63:32].
  - `tag_out` = captured tag.
  - Both are registered on entry to DONE.
  - `done`=1 for this cycle only; next state is IDLE.
- `rst` or `move_flush`, in any state:
  - Next state is IDLE.
  - `done`=0, `busy`=0, `result`=0, `tag_out`=0.
  - Accumulator and k are cleared.
  - An operation in flight is discarded and never completes.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `tag_out`=0.
- Cycle numbering: cycle 0 is the accept cycle (IDLE, `start`=1). Cycle 1 is LOAD.
- Chunk k occupies cycles 2+6k .. 7+6k:
  - 1 cycle CSTART, then 5 cycles CWAIT.
  - The sub-multiplier's `done` is observed on the 5th cycle after its start.
- Chunk 15 accumulates at the end of cycle 97. FIXUP is cycle 98. DONE (`done`=1) is cycle 99.
- The latency is fixed at 99 cycles from accept to `done`, independent of operand values.
- `busy`=1 from cycle 1 through cycle 99 inclusive.
- Earliest next accept is cycle 100.
- Flush on cycle n:
  - `busy`=0 on cycle n+1.
  - A `start` on cycle n+1 is accepted.

## Test plan
- MUL, a=7, b=6, tag=0x13 → on cycle 99: `done`=1, `result`=0x0000002A, `tag_out`=0x13. `done`=0 on cycles 1-98 and on cycle 100.
- a=b=0xFFFFFFFF → MUL 0x00000001; MULH 0x00000000; MULHU 0xFFFFFFFE; MULHSU 0xFFFFFFFF.
- a=b=0x80000000 → MULH 0x40000000; MULHU 0x40000000. MULHSU with a=0x80000000, b=0x00000002 → 0xFFFFFFFF.
- Accept on cycle 0, then assert `start` again and change `a`/`b` on cycles 5-60 → request is ignored and the result matches the cycle-0 operands. Separately, assert `move_flush` on cycle 50 → `busy`=0 on cycle 51 and `done` is never pulsed. A new MULHU with a=0x12345678, b=0x9ABCDEF0 accepted on cycle 51 gives `done` on cycle 150 with `result`=0x0B00EA4E.
- Assert `rst` on the DONE cycle → `done` is still 1 that cycle; `result`=0 and `busy`=0 on the next cycle.
- 10k random operands across all four mulops, checked against a 64-bit reference model, with random back-to-back accepts and random flushes → every completed result and tag matches, and there is exactly one `done` per unflushed accept.

Source files
------------

// File: rtl/rv32m_mul_sequencer.sv
// +----------------------------------------------------------------------------+
// | rv32m_mul_sequencer : iterative RV32M MUL/MULH/MULHSU/MULHU unit built from |
// |                       sixteen 8x8 sub-products, tagged result writeback.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dadda_multiplier8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_flush,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] p
);
  localparam logic [2:0] C_LAST_STAGE = 3'd5;

  logic [2:0]  r_stage;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_lo;
  logic [15:0] r_hi;
  logic [15:0] r_p;
  logic [15:0] w_pp [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = r_b[i] ? ({8'h00, r_a} << i) : 16'h0000;
    end
  end

  // Operands latch on start; rows reduce in two halves, then a final add.
  always_ff @(posedge clk) begin
    if (rst || move_flush) begin
      r_stage <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_p     <= '0;
    end else begin
      if (r_stage == 3'd0) begin
        if (start) begin
          r_stage <= 3'd1;
          r_a     <= a;
          r_b     <= b;
        end
      end else if (r_stage == C_LAST_STAGE) begin
        r_stage <= 3'd0;
      end else begin
        r_stage <= r_stage + 3'd1;
      end
      if (r_stage == 3'd1) begin
        r_lo <= w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];
        r_hi <= w_pp[4] + w_pp[5] + w_pp[6] + w_pp[7];
      end
      if (r_stage == 3'd2) begin
        r_p <= r_lo + r_hi;
      end
    end
  end

  assign done = (r_stage == C_LAST_STAGE);
  assign p    = r_p;
endmodule

module rv32m_mul_sequencer #(
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 move_flush,
  input  logic                 start,
  input  logic [1:0]           mulop,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          result,
  output logic [TAG_WIDTH-1:0] tag_out
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CSTART = 3'd2,
    S_CWAIT  = 3'd3,
    S_FIXUP  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [31:0]          r_mag_a;
  logic [31:0]          r_mag_b;
  logic                 r_neg;
  logic [63:0]          r_acc;
  logic [3:0]           r_k;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [TAG_WIDTH-1:0] r_tag_out;
  logic [31:0]          r_result;

  logic                 w_a_signed;
  logic                 w_b_signed;
  logic                 w_sub_start;
  logic                 w_sub_done;
  logic [15:0]          w_sub_p;
  logic [7:0]           w_sub_a;
  logic [7:0]           w_sub_b;
  logic [2:0]           w_shift;
  logic [63:0]          w_chunk;
  logic [63:0]          w_final;

  assign w_a_signed = (r_op == 2'b01) || (r_op == 2'b10);
  assign w_b_signed = (r_op == 2'b01);

  assign w_sub_a = r_mag_a[{r_k[3:2], 3'b000} +: 8];
  assign w_sub_b = r_mag_b[{r_k[1:0], 3'b000} +: 8];
  assign w_shift = {1'b0, r_k[3:2]} + {1'b0, r_k[1:0]};
  assign w_chunk = {48'h0, w_sub_p} << {w_shift, 3'b000};
  assign w_final = r_neg ? (64'd0 - r_acc) : r_acc;

  dadda_multiplier8 u_dadda (
    .clk        (clk),
    .rst        (rst),
    .move_flush (move_flush),
    .start      (w_sub_start),
    .a          (w_sub_a),
    .b          (w_sub_b),
    .done       (w_sub_done),
    .p          (w_sub_p)
  );

  always_ff @(posedge clk) begin
    if (rst || move_flush) r_state <= S_IDLE;
    else                   r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_sub_start = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = S_CSTART;
      S_CSTART: begin
        w_sub_start = 1'b1;
        w_next      = S_CWAIT;
      end
      S_CWAIT:  if (w_sub_done) w_next = (r_k == 4'd15) ? S_FIXUP : S_CSTART;
      S_FIXUP:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || move_flush) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_k       <= '0;
      r_tag     <= '0;
      r_tag_out <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op  <= mulop;
          r_a   <= a;
          r_b   <= b;
          r_tag <= tag_in;
        end
        S_LOAD: begin
          r_mag_a <= (w_a_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
          r_mag_b <= (w_b_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
          r_neg   <= (w_a_signed & r_a[31]) ^ (w_b_signed & r_b[31]);
          r_acc   <= '0;
          r_k     <= '0;
        end
        S_CWAIT: if (w_sub_done) begin
          r_acc <= r_acc + w_chunk;
          if (r_k != 4'd15) r_k <= r_k + 4'd1;
        end
        // Result is taken from the sign-corrected sum on the same edge it is stored.
        S_FIXUP: begin
          r_acc     <= w_final;
          r_result  <= (r_op == 2'b00) ? w_final[31:0] : w_final[63:32];
          r_tag_out <= r_tag;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign result  = r_result;
  assign tag_out = r_tag_out;
endmodule

`default_nettype wire
